// File: rtl/order_chk_seq_if.sv
// Bundle between the increment-chain netlist and its result sequencer.
// The master side drives chain values; the slave side reports the verdict.
interface order_chk_seq_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic [WIDTH-1:0] e_in;
    logic [WIDTH-1:0] a2_in;
    logic [7:0]       mode;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [WIDTH-1:0] cap_e;
    logic [WIDTH-1:0] cap_a2;

    modport master (
        output in_valid, e_in, a2_in,
        input  mode, done, pass, fail_code, cap_e, cap_a2
    );

    modport slave (
        input  in_valid, e_in, a2_in,
        output mode, done, pass, fail_code, cap_e, cap_a2
    );
endinterface

// File: rtl/order_chk_seq.sv
// Result sequencer: settle, check HOLD matching cycles, then a sticky verdict.
// A watchdog forces a timeout failure if no verdict is reached in time.
module order_chk_seq #(
    parameter int WIDTH   = 5,
    parameter int SETTLE  = 5,
    parameter int HOLD    = 2,
    parameter int EXP_E   = 5,
    parameter int EXP_A2  = 2,
    parameter int TIMEOUT = 32
) (
    input logic            fastclk,
    input logic            reset_l,
    order_chk_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] EXP_E_V    = WIDTH'(EXP_E);
    localparam logic [WIDTH-1:0] EXP_A2_V   = WIDTH'(EXP_A2);
    localparam logic [7:0]       SETTLE_END = 8'(SETTLE - 1);
    localparam logic [7:0]       HOLD_END   = 8'(HOLD - 1);
    localparam logic [7:0]       TMO_END    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t           state;
    logic [7:0]       mode_q;
    logic [7:0]       hold_cnt;
    logic [7:0]       tmo_cnt;
    logic             done_q;
    logic             pass_q;
    logic [1:0]       code_q;
    logic [WIDTH-1:0] cap_e_q;
    logic [WIDTH-1:0] cap_a2_q;

    logic             e_bad;
    logic             a2_bad;
    logic             tmo_hit;
    logic [7:0]       mode_inc;

    assign e_bad    = bus.e_in != EXP_E_V;
    assign a2_bad   = bus.a2_in != EXP_A2_V;
    assign tmo_hit  = tmo_cnt == TMO_END;
    assign mode_inc = (mode_q == 8'hff) ? mode_q : mode_q + 8'd1;

    always_ff @(posedge fastclk) begin
        if (!reset_l) begin
            state    <= ST_IDLE;
            mode_q   <= '0;
            hold_cnt <= '0;
            tmo_cnt  <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            code_q   <= 2'd0;
            cap_e_q  <= '0;
            cap_a2_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state   <= ST_SETTLE;
                        mode_q  <= '0;
                        tmo_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus.in_valid) begin
                        mode_q <= mode_inc;
                        if (mode_q == SETTLE_END) begin
                            state    <= ST_CHECK;
                            hold_cnt <= '0;
                        end
                    end
                    // Entering CHECK is not a verdict, so the watchdog still wins
                    if (tmo_hit) begin
                        state  <= ST_FAIL;
                        done_q <= 1'b1;
                        code_q <= 2'd3;
                    end
                end
                ST_CHECK: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus.in_valid)
                        mode_q <= mode_inc;
                    if (bus.in_valid && (e_bad || a2_bad)) begin
                        state    <= ST_FAIL;
                        done_q   <= 1'b1;
                        code_q   <= e_bad ? 2'd1 : 2'd2;
                        cap_e_q  <= bus.e_in;
                        cap_a2_q <= bus.a2_in;
                    end else if (bus.in_valid && hold_cnt == HOLD_END) begin
                        state    <= ST_PASS;
                        done_q   <= 1'b1;
                        pass_q   <= 1'b1;
                        hold_cnt <= hold_cnt + 8'd1;
                    end else begin
                        if (bus.in_valid)
                            hold_cnt <= hold_cnt + 8'd1;
                        if (tmo_hit) begin
                            state  <= ST_FAIL;
                            done_q <= 1'b1;
                            code_q <= 2'd3;
                        end
                    end
                end
                ST_PASS, ST_FAIL: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mode      = mode_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_code = code_q;
    assign bus.cap_e     = cap_e_q;
    assign bus.cap_a2    = cap_a2_q;
endmodule
